// File: rtl/page_stream_qout.sv
// Output-side page stream queue: FWFT FIFO of {eos,data} tokens with
// registered back-pressure threshold and sticky overflow flag.
module page_stream_qout #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int SLACK = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [W-1:0]             qin_d,
  input  logic                     qin_e,
  input  logic                     qin_v,
  output logic                     qin_b,
  output logic [W-1:0]             qout_d,
  output logic                     qout_e,
  output logic                     qout_v,
  input  logic                     qout_b,
  output logic [$clog2(DEPTH):0]   occ,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL_C = OW'(DEPTH);
  localparam logic [OW-1:0] THR_C  = OW'(DEPTH - SLACK);

  logic [W:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          ovf_q, ovf_d;

  logic deq, enq, full;

  always_comb begin
    full  = (occ_q == FULL_C);
    deq   = (occ_q != '0) && !qout_b;
    // a full queue still accepts when the head leaves on the same edge
    enq   = qin_v && (!full || deq);
    rd_d  = rd_q;
    wr_d  = wr_q;
    occ_d = occ_q;
    ovf_d = ovf_q;
    if (deq) rd_d = rd_q + AW'(1);
    if (enq) wr_d = wr_q + AW'(1);
    unique case ({enq, deq})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    if (qin_v && !enq) ovf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      occ_q <= occ_d;
      ovf_q <= ovf_d;
    end
  end

  // storage needs no reset; occupancy alone decides validity
  always_ff @(posedge clock) begin
    if (!reset && enq) mem_q[wr_q] <= {qin_e, qin_d};
  end

  assign qout_v = (occ_q != '0);
  assign qout_d = mem_q[rd_q][W-1:0];
  assign qout_e = mem_q[rd_q][W];
  assign qin_b  = (occ_q >= THR_C);
  assign occ    = occ_q;
  assign ovf    = ovf_q;

endmodule
